// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t    : owner of the current memory cycle (idle / CPU / DMA)
//   PORT_C, PORT_D : grant-vector indices for the CPU and DMA ports
//   WORD_LSB/MSB   : byte-address bits that select a 32-bit word
//   addr_in_range  : word index below the memory depth
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } arb_state_t;

    localparam int unsigned PORT_C   = 0;
    localparam int unsigned PORT_D   = 1;

    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned WORD_MSB = 13;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;

    // Word index lies inside the populated part of the memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return 32'(addr[WORD_MSB:WORD_LSB]) < depth;
    endfunction

endpackage

// File: rtl/dmem_arb_port_ret.sv
// Per-port read-return register for the data-memory arbiter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   issue     : this port owns the memory this cycle
//   we        : the issued access is a write
//   oor       : the issued address is out of range
//   rd        : memory read data during the issue cycle
//   state     : registered owner of the previous cycle
//   rdata     : returned read data (held between returns)
//   rvalid    : return/ack pulse, one cycle after issue
//   err       : out-of-range flag, pulses with rvalid
module dmem_arb_port_ret
    import dmem_arb_pkg::*;
#(
    parameter arb_state_t OWNER = S_CPU
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              we,
    input  logic              oor,
    input  logic [DATA_W-1:0] rd,
    input  arb_state_t        state,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    // Capture read data in the issue cycle; writes leave rdata untouched,
    // out-of-range accesses return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            err <= issue && oor;
            if (issue) begin
                if (oor) begin
                    rdata <= '0;
                end else if (!we) begin
                    rdata <= rd;
                end
            end
        end
    end

    // The registered owner is exactly the port whose return lands this cycle.
    assign rvalid = (state == OWNER);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage (port C) and the
// RSA loader DMA (port D). Fixed CPU priority; a DMA request that has waited
// MAX_WAIT cycles is forced ahead of the CPU.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata     : CPU request
//   c_gnt                         : CPU access issued this cycle (combinational)
//   c_rdata/c_rvalid/c_err        : CPU return, one cycle after grant
//   d_*                           : same set for the DMA port
//   mem_we/mem_a/mem_wd           : memory write enable, address, write data
//   mem_rd                        : memory combinational read data
// Build option: define DMEM_ARB_TRACE_EN to print every in-range write and
// every out-of-range access; the logic is identical either way.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 102,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_full;
    logic              c_ok;
    logic              d_ok;
    logic [1:0]        gnt;

    assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign c_ok      = addr_in_range(c_addr, DEPTH);
    assign d_ok      = addr_in_range(d_addr, DEPTH);

    // Owner register: remembers who used the memory in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner of the current cycle: DMA only when the CPU is idle or DMA has starved.
    always_comb begin
        state_nxt = S_IDLE;
        if (d_req && (!c_req || wait_full)) begin
            state_nxt = S_DMA;
        end else if (c_req) begin
            state_nxt = S_CPU;
        end
    end

    // Grants and memory drive; everything is held low while in reset.
    always_comb begin
        gnt    = '0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (!rst) begin
            case (state_nxt)
                S_CPU: begin
                    gnt[PORT_C] = 1'b1;
                    mem_a       = c_addr;
                    mem_wd      = c_wdata;
                    mem_we      = c_we && c_ok;
                end
                S_DMA: begin
                    gnt[PORT_D] = 1'b1;
                    mem_a       = d_addr;
                    mem_wd      = d_wdata;
                    mem_we      = d_we && d_ok;
                end
                default: begin
                end
            endcase
        end
    end

    assign c_gnt = gnt[PORT_C];
    assign d_gnt = gnt[PORT_D];

    // Starvation counter: cycles the DMA has been kept waiting, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!d_req || gnt[PORT_D]) begin
            wait_cnt <= '0;
        end else if (!wait_full) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    dmem_arb_port_ret #(
        .OWNER (S_CPU)
    ) u_ret_c (
        .clk    (clk),
        .rst    (rst),
        .issue  (gnt[PORT_C]),
        .we     (c_we),
        .oor    (!c_ok),
        .rd     (mem_rd),
        .state  (state),
        .rdata  (c_rdata),
        .rvalid (c_rvalid),
        .err    (c_err)
    );

    dmem_arb_port_ret #(
        .OWNER (S_DMA)
    ) u_ret_d (
        .clk    (clk),
        .rst    (rst),
        .issue  (gnt[PORT_D]),
        .we     (d_we),
        .oor    (!d_ok),
        .rd     (mem_rd),
        .state  (state),
        .rdata  (d_rdata),
        .rvalid (d_rvalid),
        .err    (d_err)
    );

`ifdef DMEM_ARB_TRACE_EN
    // Access trace: in-range writes and out-of-range accesses of either port.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                $display("[dmem_arb] %s write addr=0x%08h data=0x%08h (%0d)",
                         gnt[PORT_D] ? "DMA" : "CPU", mem_a, mem_wd, mem_wd);
            end
            if (gnt[PORT_C] && !c_ok) begin
                $display("[dmem_arb] CPU err addr=0x%08h", c_addr);
            end
            if (gnt[PORT_D] && !d_ok) begin
                $display("[dmem_arb] DMA err addr=0x%08h", d_addr);
            end
        end
    end
`else
    // No trace output in this build.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model (priority rule, wait count, shadow memory).
module tb_dmem_arbiter;

    localparam int DEPTH    = 102;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rdata  (c_rdata),
        .c_rvalid (c_rvalid),
        .c_err    (c_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rdata  (d_rdata),
        .d_rvalid (d_rvalid),
        .d_err    (d_err),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // Data memory with a bench-side preload port.
    logic [31:0] ram [0:127];
    logic        pl_en;
    logic [6:0]  pl_idx;
    logic [31:0] pl_data;

    assign mem_rd = (int'(mem_a[13:2]) < DEPTH) ? ram[mem_a[8:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we) ram[mem_a[8:2]] <= mem_wd;
        else if (pl_en) ram[pl_idx] <= pl_data;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:127];
    int          wcnt;
    logic [31:0] e_rdata  [2];
    logic        e_rvalid [2];
    logic        e_err    [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One arbitration cycle. Entered just after a posedge; returns just after the next.
    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        output logic og_c, output logic og_d);
        logic        gc, gd, w;
        logic [31:0] a, wd;
        int          idx, p;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        gd = dr && (!cr || wcnt == MAX_WAIT);
        gc = cr && !gd;
        a  = gd ? da : (gc ? ca : 32'h0);
        wd = gd ? dd : (gc ? cd : 32'h0);
        w  = gd ? dw : cw;
        idx = int'(a[13:2]);
        #2;
        og_c = c_gnt;
        og_d = d_gnt;
        check("c_gnt",  32'(c_gnt),  32'(gc));
        check("d_gnt",  32'(d_gnt),  32'(gd));
        check("mem_a",  mem_a,  a);
        check("mem_wd", mem_wd, wd);
        check("mem_we", 32'(mem_we), 32'((gc || gd) && w && idx < DEPTH));
        for (int k = 0; k < 2; k++) begin
            e_rvalid[k] = 1'b0;
            e_err[k]    = 1'b0;
        end
        if (gc || gd) begin
            p = gd ? 1 : 0;
            e_rvalid[p] = 1'b1;
            if (idx >= DEPTH) begin
                e_err[p]   = 1'b1;
                e_rdata[p] = 32'h0;
            end else if (w) begin
                ref_mem[idx] = wd;
            end else begin
                e_rdata[p] = ref_mem[idx];
            end
        end
        if (!dr || gd) wcnt = 0;
        else if (wcnt < MAX_WAIT) wcnt++;
        @(posedge clk);
        #1;
        check("c_rvalid", 32'(c_rvalid), 32'(e_rvalid[0]));
        check("c_err",    32'(c_err),    32'(e_err[0]));
        check("c_rdata",  c_rdata,       e_rdata[0]);
        check("d_rvalid", 32'(d_rvalid), 32'(e_rvalid[1]));
        check("d_err",    32'(d_err),    32'(e_err[1]));
        check("d_rdata",  d_rdata,       e_rdata[1]);
    endtask

    task automatic model_reset();
        wcnt = 0;
        for (int k = 0; k < 2; k++) begin
            e_rdata[k]  = 32'h0;
            e_rvalid[k] = 1'b0;
            e_err[k]    = 1'b0;
        end
    endtask

    logic        gc, gd;
    logic        cp, cpw, dp, dpw;
    logic [31:0] cpa, cpd, dpa, dpd;

    initial begin
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        pl_en = 0; pl_idx = 0; pl_data = 0;
        model_reset();

        // Preload memory while in reset; word 2 holds 0xCAFE.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = 7'(i);
            pl_data = (i == 2) ? 32'h0000_CAFE : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;

        check("rst_c_gnt",    32'(c_gnt),    32'h0);
        check("rst_d_gnt",    32'(d_gnt),    32'h0);
        check("rst_mem_we",   32'(mem_we),   32'h0);
        check("rst_mem_a",    mem_a,         32'h0);
        check("rst_c_rvalid", 32'(c_rvalid), 32'h0);
        check("rst_c_rdata",  c_rdata,       32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_d_err",    32'(d_err),    32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // CPU read of word 2.
        step(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, gc, gd);
        check("t1_gnt",   32'(gc),      32'h1);
        check("t1_rdata", c_rdata,      32'h0000_CAFE);

        // Both requesting continuously: four CPU grants then one DMA grant.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'(i * 4), 32'h0, 1, 0, 32'(32'h40 + i * 4), 32'h0, gc, gd);
            check("t2_d_gnt", 32'(gd), 32'(i % 5 == 4));
            check("t2_c_gnt", 32'(gc), 32'(i % 5 != 4));
        end

        // DMA write then CPU read-back.
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'h1234, gc, gd);
        check("t3_d_gnt", 32'(gd), 32'h1);
        check("t3_ram",   ram[4],  32'h1234);
        step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, gc, gd);
        check("t3_rdata", c_rdata, 32'h1234);

        // CPU write to word 102 (out of range).
        step(1, 1, 32'h198, 32'h5555_AAAA, 0, 0, 32'h0, 32'h0, gc, gd);
        check("t4_err",   32'(c_err), 32'h1);
        check("t4_rdata", c_rdata,    32'h0);

        // Back-to-back CPU reads of words 0,1,2.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'(i * 4), 32'h0, 0, 0, 32'h0, 32'h0, gc, gd);
            check("t6_gnt",    32'(gc),       32'h1);
            check("t6_rvalid", 32'(c_rvalid), 32'h1);
            check("t6_data",   c_rdata,       ref_mem[i]);
        end

        // Reset arriving while a CPU write is granted.
        c_req = 1; c_we = 1; c_addr = 32'h14; c_wdata = 32'hDEAD_0001;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        #2;
        check("t5_pre_we", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_mem_we",   32'(mem_we),   32'h0);
        check("t5_c_gnt",    32'(c_gnt),    32'h0);
        check("t5_mem_a",    mem_a,         32'h0);
        check("t5_mem_wd",   mem_wd,        32'h0);
        check("t5_c_rdata",  c_rdata,       32'h0);
        check("t5_c_rvalid", 32'(c_rvalid), 32'h0);
        check("t5_c_err",    32'(c_err),    32'h0);
        c_req = 0; c_we = 0;
        @(posedge clk);
        #1;
        check("t5_ram", ram[5], ref_mem[5]);
        rst = 1'b0;
        model_reset();

        // Random traffic; each requester holds its request until granted.
        cp = 0; dp = 0; cpw = 0; dpw = 0; cpa = 0; cpd = 0; dpa = 0; dpd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 9) < 6) begin
                cp  = 1'b1;
                cpw = 1'($urandom_range(0, 1));
                cpa = (32'($urandom_range(0, 110)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) cpa = cpa | ($urandom & 32'hFFFF_C000);
                cpd = $urandom;
            end
            if (!dp && $urandom_range(0, 9) < 5) begin
                dp  = 1'b1;
                dpw = 1'($urandom_range(0, 1));
                dpa = (32'($urandom_range(0, 110)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) dpa = dpa | ($urandom & 32'hFFFF_C000);
                dpd = $urandom;
            end
            step(cp, cpw, cpa, cpd, dp, dpw, dpa, dpd, gc, gd);
            check("rnd_one_gnt", 32'(gc && gd), 32'h0);
            if (gc) cp = 1'b0;
            if (gd) dp = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
